// File: rtl/pool_result_collector_if.sv
// Valid/ready stream carrying pooled values from the pooling engine into the collector.
interface pool_result_collector_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pool_result_collector.sv
// Collects the serial pooled-value stream into a row-major 2-D output map, sizing the
// map as ceil(imgSize/windowSize) by repeated addition and tracking the write position.
module pool_result_collector #(
    parameter int N    = 32,
    parameter int DW   = 16,
    parameter int MAXW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [15:0]          imgSize,
    input  logic [15:0]          windowSize,
    pool_result_collector_if.slave in_if,
    output logic signed [DW-1:0] outImage [0:N*N-1],
    output logic [15:0]          outSize,
    output logic [15:0]          row,
    output logic [15:0]          col,
    output logic [15:0]          count,
    output logic                 done,
    output logic                 err
);

    localparam int          IW     = $clog2(N*N);
    localparam logic [15:0] N_L    = 16'(N);
    localparam logic [15:0] MAXW_L = 16'(MAXW);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        COLLECT = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [15:0]          img_r;
    logic [15:0]          win_r;
    logic [15:0]          acc_r;
    logic [15:0]          outsize_r;
    logic [15:0]          row_r;
    logic [15:0]          col_r;
    logic [15:0]          count_r;
    logic                 done_r;
    logic                 err_r;
    logic                 in_ready_r;
    logic signed [DW-1:0] image_r [0:N*N-1];

    logic                 cfg_bad_s;
    logic                 hs_s;
    logic [15:0]          last_s;
    logic [IW-1:0]        idx_s;

    assign cfg_bad_s = (windowSize == 16'd0) || (windowSize > MAXW_L) ||
                       (imgSize == 16'd0) || (imgSize > N_L);
    // A start on the same edge as a beat restarts the map, so that beat is dropped.
    assign hs_s   = (state_r == COLLECT) && in_if.in_valid && in_ready_r && !start;
    assign last_s = outsize_r * outsize_r - 16'd1;
    assign idx_s  = row_r[IW-1:0] * outsize_r[IW-1:0] + col_r[IW-1:0];

    assign in_if.in_ready = in_ready_r;
    assign outImage       = image_r;
    assign outSize        = outsize_r;
    assign row            = row_r;
    assign col            = col_r;
    assign count          = count_r;
    assign done           = done_r;
    assign err            = err_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; start overrides whatever the current state is doing.
    always_comb begin
        state_s = state_r;
        if (start) begin
            if (cfg_bad_s) begin
                state_s = ERR;
            end else begin
                state_s = CALC;
            end
        end else begin
            case (state_r)
                IDLE: state_s = IDLE;
                CALC: begin
                    if ((acc_r + win_r) >= img_r) begin
                        state_s = COLLECT;
                    end else begin
                        state_s = CALC;
                    end
                end
                COLLECT: begin
                    if (hs_s && (count_r == last_s)) begin
                        state_s = DONE;
                    end else begin
                        state_s = COLLECT;
                    end
                end
                DONE:    state_s = DONE;
                ERR:     state_s = ERR;
                default: state_s = IDLE;
            endcase
        end
    end

    // Datapath: parameter latch, size accumulation, map writes and registered status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            img_r      <= 16'd0;
            win_r      <= 16'd0;
            acc_r      <= 16'd0;
            outsize_r  <= 16'd0;
            row_r      <= 16'd0;
            col_r      <= 16'd0;
            count_r    <= 16'd0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            in_ready_r <= 1'b0;
            for (int i = 0; i < N*N; i++) begin
                image_r[i] <= {DW{1'b0}};
            end
        end else begin
            if (start) begin
                img_r     <= imgSize;
                win_r     <= windowSize;
                acc_r     <= 16'd0;
                outsize_r <= 16'd0;
                row_r     <= 16'd0;
                col_r     <= 16'd0;
                count_r   <= 16'd0;
            end else if (state_r == CALC) begin
                acc_r     <= acc_r + win_r;
                outsize_r <= outsize_r + 16'd1;
            end else if (hs_s) begin
                image_r[idx_s] <= in_if.in_data;
                count_r        <= count_r + 16'd1;
                if (col_r == (outsize_r - 16'd1)) begin
                    col_r <= 16'd0;
                    row_r <= row_r + 16'd1;
                end else begin
                    col_r <= col_r + 16'd1;
                end
            end
            in_ready_r <= (state_s == COLLECT);
            done_r     <= (state_s == DONE);
            err_r      <= (state_s == ERR);
        end
    end

endmodule

// File: tb/tb_pool_result_collector.sv
// Directed bench for pool_result_collector: sizing, stream reassembly, errors, abort and reset.
module tb_pool_result_collector;

    logic              clk;
    logic              reset;
    logic              start;
    logic [15:0]       imgSize;
    logic [15:0]       windowSize;
    logic signed [15:0] out_image [0:1023];
    logic [15:0]       out_size;
    logic [15:0]       row;
    logic [15:0]       col;
    logic [15:0]       count;
    logic              done;
    logic              err;

    int cmp_cnt = 0;
    int err_cnt = 0;

    pool_result_collector_if #(.DW(16)) bus ();

    pool_result_collector #(.N(32), .DW(16), .MAXW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imgSize    (imgSize),
        .windowSize (windowSize),
        .in_if      (bus.slave),
        .outImage   (out_image),
        .outSize    (out_size),
        .row        (row),
        .col        (col),
        .count      (count),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] img, input logic [15:0] win);
        start      = 1'b1;
        imgSize    = img;
        windowSize = win;
        step();
        start = 1'b0;
    endtask

    // Counts cycles from the start edge until in_ready rises, bounded.
    task automatic wait_collect(input string tag, input int exp_cyc);
        int cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 64) begin
            step();
            cyc++;
        end
        check_val(tag, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic send(input logic signed [15:0] val);
        bus.in_valid = 1'b1;
        bus.in_data  = val;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        imgSize      = 16'd0;
        windowSize   = 16'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'sd0;
        #1;
        check_val("rst_outsize", 32'(out_size), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_ready", 32'(bus.in_ready), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        #20;
        reset = 1'b1;
        step();

        // 1: 4x4 image, 2x2 window
        do_start(16'd4, 16'd2);
        check_val("t1_calc_os0", 32'(out_size), 32'd0);
        wait_collect("t1_calc_cycles", 2);
        check_val("t1_outsize", 32'(out_size), 32'd2);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(10 * (i + 1));
            step();
            if (i == 2) check_val("t1_done_early", 32'(done), 32'd0);
        end
        bus.in_valid = 1'b0;
        check_val("t1_done", 32'(done), 32'd1);
        check_val("t1_ready_low", 32'(bus.in_ready), 32'd0);
        check_val("t1_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) check_val("t1_img", 32'(out_image[i]), 32'(10 * (i + 1)));

        // 2: 5x5 image, window 2 -> 3x3 map
        do_start(16'd5, 16'd2);
        check_val("t2_done_cleared", 32'(done), 32'd0);
        wait_collect("t2_calc_cycles", 3);
        check_val("t2_outsize", 32'(out_size), 32'd3);
        for (int i = 1; i <= 9; i++) begin
            send(16'(i));
            if (i == 3 || i == 6) begin
                check_val("t2_col_wrap", 32'(col), 32'd0);
                check_val("t2_row_step", 32'(row), 32'(i / 3));
            end
        end
        check_val("t2_img8", 32'(out_image[8]), 32'd9);
        check_val("t2_img4", 32'(out_image[4]), 32'd5);
        check_val("t2_row_done", 32'(row), 32'd3);
        check_val("t2_done", 32'(done), 32'd1);

        // Boundary: largest valid image with largest window -> ceil(32/5)=7
        do_start(16'd32, 16'd5);
        wait_collect("b_calc_cycles", 7);
        check_val("b_outsize", 32'(out_size), 32'd7);
        do_start(16'd33, 16'd2);
        check_val("b_img_too_big", 32'(err), 32'd1);
        do_start(16'd4, 16'd6);
        check_val("b_win_too_big", 32'(err), 32'd1);
        do_start(16'd0, 16'd1);
        check_val("b_img_zero", 32'(err), 32'd1);

        // 3: zero window -> error, then recover
        do_start(16'd4, 16'd0);
        check_val("t3_err", 32'(err), 32'd1);
        check_val("t3_ready", 32'(bus.in_ready), 32'd0);
        check_val("t3_outsize", 32'(out_size), 32'd0);
        send(16'sd55);
        send(16'sd56);
        check_val("t3_err_hold", 32'(err), 32'd1);
        check_val("t3_count_hold", 32'(count), 32'd0);
        do_start(16'd3, 16'd1);
        check_val("t3_err_clear", 32'(err), 32'd0);
        wait_collect("t3_calc_cycles", 3);
        check_val("t3_outsize2", 32'(out_size), 32'd3);
        for (int i = 0; i < 9; i++) send(16'(100 + i));
        check_val("t3_count9", 32'(count), 32'd9);
        check_val("t3_done", 32'(done), 32'd1);
        check_val("t3_img8", 32'(out_image[8]), 32'd108);

        // 4: gapped stream with negative data
        do_start(16'd4, 16'd2);
        wait_collect("t4_calc_cycles", 2);
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = (i % 2 == 0) ? 16'(-4 * (i / 2 + 1)) : 16'sh7777;
            step();
            check_val("t4_count", 32'(count), 32'(i / 2 + 1));
        end
        bus.in_valid = 1'b0;
        check_val("t4_done", 32'(done), 32'd1);
        check_val("t4_img3", 32'(out_image[3]), 32'hFFFF_FFF0);
        check_val("t4_img0", 32'(out_image[0]), 32'hFFFF_FFFC);

        // 5: asynchronous reset mid-map
        do_start(16'd4, 16'd2);
        wait_collect("t5_calc_cycles", 2);
        send(16'sd5);
        send(16'sd6);
        #2;
        reset = 1'b0;
        #1;
        check_val("t5_img0", 32'(out_image[0]), 32'd0);
        check_val("t5_img1", 32'(out_image[1]), 32'd0);
        check_val("t5_count", 32'(count), 32'd0);
        check_val("t5_done", 32'(done), 32'd0);
        check_val("t5_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        send(16'sd77);
        step();
        check_val("t5_idle_ready", 32'(bus.in_ready), 32'd0);
        check_val("t5_idle_count", 32'(count), 32'd0);
        do_start(16'd4, 16'd2);
        wait_collect("t5_calc2", 2);
        for (int i = 0; i < 4; i++) send(16'(50 + i));
        check_val("t5_done2", 32'(done), 32'd1);
        check_val("t5_img2", 32'(out_image[2]), 32'd52);

        // 6: restart in COLLECT drops the concurrent beat
        do_start(16'd4, 16'd2);
        wait_collect("t6_calc_cycles", 2);
        send(16'sd77);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'sd99;
        do_start(16'd4, 16'd2);
        bus.in_valid = 1'b0;
        check_val("t6_count", 32'(count), 32'd0);
        check_val("t6_row", 32'(row), 32'd0);
        check_val("t6_col", 32'(col), 32'd0);
        check_val("t6_ready", 32'(bus.in_ready), 32'd0);
        check_val("t6_img0", 32'(out_image[0]), 32'd77);
        check_val("t6_img1_kept", 32'(out_image[1]), 32'd51);
        wait_collect("t6_recalc", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pool_result_collector.md
Name: pool_result_collector

Overview:
- Sink end of the pooling datapath: accepts the serial stream of pooled values (one 16-bit signed value per handshake) produced by the pooling engine.
- Reassembles the stream, in row-major window order, into a 2-D output feature map for the next CNN layer.
- Computes the output map dimension from image and window size, tracks the row/column write position, and flags completion or a bad configuration.

Parameters:
- N, 32, maximum input image dimension; the output buffer holds N*N entries.
- DW, 16, data width (signed fixed-point).
- MAXW, 5, maximum supported window size (matches the 25-entry pooling window).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; latches imgSize/windowSize and begins a new map.
- imgSize  in  16  input image dimension (square).
- windowSize  in  16  pooling window dimension and stride.
- in_valid  in  1  pooled value present on in_data.
- in_data  in  DW  signed pooled value.
- in_ready  out  1  collector accepts in_data this cycle.
- outImage  out  DW x N*N  unpacked array [0:N*N-1], row-major output map.
- outSize  out  16  output map dimension, ceil(imgSize/windowSize).
- row  out  16  current write row.
- col  out  16  current write column.
- count  out  16  values accepted since start.
- done  out  1  map complete.
- err  out  1  configuration rejected.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - all outImage entries, outSize, row, col, count, done, err, in_ready go to 0;
  - state goes to IDLE.
  - Reset asserted mid-operation aborts the map; no partial state survives.
- States: IDLE, CALC, COLLECT, DONE, ERR. A handshake occurs on a rising edge with in_valid=1 and in_ready=1.
- IDLE:
  - in_ready=0.
  - start -> latch params, clear row/col/count/done/err.
  - If windowSize==0, windowSize>MAXW, imgSize==0 or imgSize>N -> ERR; otherwise -> CALC with acc=0 and outSize=0.
- CALC (no divider):
  - Each cycle: acc+=windowSize and outSize+=1.
  - When acc+windowSize >= imgSize on that cycle -> COLLECT.
  - CALC therefore lasts exactly outSize cycles; outSize is final on COLLECT entry. in_ready=0.
- COLLECT:
  - in_ready=1.
  - On handshake:
    - outImage[row*outSize+col] <= in_data;
    - count+=1;
    - col+=1, except when col==outSize-1: col=0 and row+=1.
  - On the handshake with count==outSize*outSize-1 -> DONE.
  - done=1 and in_ready=0 from the following cycle.
  - Beats with in_valid=0 leave all counters unchanged.
- DONE:
  - done=1, in_ready=0; outImage, outSize and count hold.
  - start -> re-latch params and proceed as from IDLE; done clears on that edge.
- ERR:
  - err=1, in_ready=0, outSize=0.
  - Only start (with valid params) or reset leaves ERR.
- start in CALC or COLLECT: abort and restart as from IDLE.
  - start wins over a simultaneous in_valid; that beat is dropped and not written.
- outImage is cleared only by reset. A restart leaves stale entries, and entries beyond outSize*outSize are never written.
- in_valid outside COLLECT is ignored with no side effects.
- Arithmetic:
  - index row*outSize+col is computed unsigned and is always < N*N, since outSize<=N;
  - in_data is stored verbatim with no sign change or saturation.

Test Plan:
1. imgSize=4, windowSize=2, start; stream 10,20,30,40 back-to-back -> CALC 2 cycles, outSize=2, outImage[0..3]=10,20,30,40, done=1 and in_ready=0 one cycle after the 4th handshake, count=4.
2. imgSize=5, windowSize=2 -> outSize=3 after 3 CALC cycles; 9 values 1..9 -> col wraps 2->0 after values 3 and 6, outImage[8]=9, row=3 at done.
3. windowSize=0, start -> err=1, in_ready=0, outSize=0; then start with imgSize=3, windowSize=1 -> err=0, outSize=3 after 3 cycles, 9 values accepted.
4. imgSize=4, windowSize=2 with in_valid toggling 1,0,1,0 and negative data -4,-8,-12,-16 -> count advances only on handshakes, outImage[3]=-16, done after the 4th accepted value.
5. reset pulled low asynchronously (between edges) after 2 of 4 values -> outImage[0..1], count, done, in_ready read 0 before the next clk edge; state IDLE; a fresh start then completes normally.
6. In COLLECT after 1 value, start=1 with in_valid=1, in_data=99 -> 99 not written, count=0, row=col=0, CALC re-entered; outImage[0] keeps its old value.
